// File: rtl/jtframe_kabuki_pkg.sv
// Shared Kabuki definitions: key length, loader state encodings and key checksum helper.
// Used by the key loader, the Z80 decoder and their benches.
package jtframe_kabuki_pkg;

  localparam int unsigned KABUKI_KEY_BYTES = 11;
  localparam int unsigned KABUKI_ST_W      = 3;

  localparam logic [KABUKI_ST_W-1:0] KABUKI_ST_IDLE    = 3'd0;
  localparam logic [KABUKI_ST_W-1:0] KABUKI_ST_CAPTURE = 3'd1;
  localparam logic [KABUKI_ST_W-1:0] KABUKI_ST_PUSH_HI = 3'd2;
  localparam logic [KABUKI_ST_W-1:0] KABUKI_ST_PUSH_LO = 3'd3;
  localparam logic [KABUKI_ST_W-1:0] KABUKI_ST_DONE    = 3'd4;
  localparam logic [KABUKI_ST_W-1:0] KABUKI_ST_ERR     = 3'd5;

  typedef enum logic [KABUKI_ST_W-1:0] {
    ST_IDLE    = KABUKI_ST_IDLE,
    ST_CAPTURE = KABUKI_ST_CAPTURE,
    ST_PUSH_HI = KABUKI_ST_PUSH_HI,
    ST_PUSH_LO = KABUKI_ST_PUSH_LO,
    ST_DONE    = KABUKI_ST_DONE,
    ST_ERR     = KABUKI_ST_ERR
  } kabuki_state_t;

  // XOR of all key bytes; byte 0 sits in the MSBs of the packed key
  function automatic logic [7:0] kabuki_chk(input logic [KABUKI_KEY_BYTES*8-1:0] key);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < KABUKI_KEY_BYTES; i++) x ^= key[i*8 +: 8];
    return x;
  endfunction

endpackage

// File: rtl/jtframe_kabuki_keyload.sv
// Kabuki key loader: captures the key set from the ioctl download and replays it into the
// decoder serial key port. Define JTFRAME_KABUKI_CHK_EN to require a trailing XOR checksum byte.
module jtframe_kabuki_keyload
  import jtframe_kabuki_pkg::*;
#(
  parameter int unsigned   AW       = 26,
  parameter logic [AW-1:0] KEY_ADDR = '0,
  parameter int unsigned   WE_HOLD  = 2,
  parameter int unsigned   WE_GAP   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  output logic          kabuki_en,
  output logic          busy,
  output logic          key_err
);

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 4;
`ifdef JTFRAME_KABUKI_CHK_EN
  localparam int unsigned WIN = KABUKI_KEY_BYTES + 1;
`else
  localparam int unsigned WIN = KABUKI_KEY_BYTES;
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(KABUKI_KEY_BYTES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(WE_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(WE_GAP - 1);

  kabuki_state_t  state, state_nxt;
  logic           dl_q, dl_rise, dl_fall;
  logic [7:0]     key_buf [WIN];
  logic [7:0]     buf_nxt [WIN];
  logic [WIN-1:0] mask, mask_wr, mask_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [7:0]     prog_data_nxt;
  logic           prog_we_nxt, kabuki_en_nxt, busy_nxt, key_err_nxt;
  logic [AW-1:0]  off;
  logic [IW-1:0]  wr_idx;
  logic           wr_hit;
  logic [7:0]     first_byte, next_byte;
  logic           chk_ok, complete;

  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;
  assign off     = ioctl_addr - KEY_ADDR;
  assign wr_idx  = off[IW-1:0];
  assign wr_hit  = (state == ST_CAPTURE) && ioctl_wr && (off < AW'(WIN));

  // Buffer/mask view including this cycle's write, so a write on the download's last cycle counts
  always_comb begin
    mask_wr = mask;
    for (int unsigned i = 0; i < WIN; i++) begin
      buf_nxt[i] = key_buf[i];
      if (wr_hit && wr_idx == IW'(i)) begin
        buf_nxt[i] = ioctl_dout;
        mask_wr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    first_byte = buf_nxt[0];
    next_byte  = '0;
    for (int unsigned i = 1; i < KABUKI_KEY_BYTES; i++) begin
      if (idx == IW'(i - 1)) next_byte = buf_nxt[i];
    end
  end

`ifdef JTFRAME_KABUKI_CHK_EN
  logic [KABUKI_KEY_BYTES*8-1:0] key_vec;

  always_comb begin
    key_vec = '0;
    for (int unsigned i = 0; i < KABUKI_KEY_BYTES; i++) begin
      key_vec[(KABUKI_KEY_BYTES-1-i)*8 +: 8] = buf_nxt[i];
    end
    chk_ok = (kabuki_chk(key_vec) == buf_nxt[KABUKI_KEY_BYTES]);
  end
`else
  assign chk_ok = 1'b1;
`endif

  assign complete = (mask_wr == '1) && chk_ok;

  // Next state and registered outputs; a new download start overrides everything
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = (cnt != '0) ? cnt - CW'(1) : cnt;
    mask_nxt      = mask_wr;
    prog_data_nxt = prog_data;
    prog_we_nxt   = prog_we;
    kabuki_en_nxt = kabuki_en;
    busy_nxt      = busy;
    key_err_nxt   = key_err;
    if (dl_rise) begin
      state_nxt     = ST_CAPTURE;
      idx_nxt       = '0;
      mask_nxt      = '0;
      prog_we_nxt   = 1'b0;
      kabuki_en_nxt = 1'b0;
      busy_nxt      = 1'b0;
      key_err_nxt   = 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (dl_fall) begin
            if (complete) begin
              state_nxt     = ST_PUSH_HI;
              idx_nxt       = '0;
              cnt_nxt       = HOLD_LD;
              prog_data_nxt = first_byte;
              prog_we_nxt   = 1'b1;
              busy_nxt      = 1'b1;
            end else begin
              state_nxt     = ST_ERR;
              key_err_nxt   = 1'b1;
              kabuki_en_nxt = 1'b0;
            end
          end
        end
        ST_PUSH_HI: begin
          if (cnt == '0) begin
            state_nxt   = ST_PUSH_LO;
            cnt_nxt     = GAP_LD;
            prog_we_nxt = 1'b0;
          end
        end
        ST_PUSH_LO: begin
          if (cnt == '0) begin
            if (idx == LAST_IDX) begin
              state_nxt     = ST_DONE;
              busy_nxt      = 1'b0;
              kabuki_en_nxt = 1'b1;
            end else begin
              state_nxt     = ST_PUSH_HI;
              idx_nxt       = idx + IW'(1);
              cnt_nxt       = HOLD_LD;
              prog_data_nxt = next_byte;
              prog_we_nxt   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dl_q      <= 1'b0;
      mask      <= '0;
      idx       <= '0;
      cnt       <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      kabuki_en <= 1'b0;
      busy      <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dl_q      <= downloading;
      mask      <= mask_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      prog_data <= prog_data_nxt;
      prog_we   <= prog_we_nxt;
      kabuki_en <= kabuki_en_nxt;
      busy      <= busy_nxt;
      key_err   <= key_err_nxt;
    end
  end

  // Key storage survives reset and new downloads; only the mask tracks validity
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIN; i++) key_buf[i] <= buf_nxt[i];
  end

endmodule

// File: tb/tb_jtframe_kabuki_keyload.sv
// Bench for jtframe_kabuki_keyload: per-cycle comparison against a behavioural replay model,
// plus literal checks of the decoder key register, pulse counts and latencies.
`timescale 1ns/1ps
module tb_jtframe_kabuki_keyload;

  localparam logic [25:0] KADDR = 26'h100;
  localparam int HOLD = 2;
  localparam int GAP  = 2;
  localparam int SLOT = HOLD + GAP;
  localparam int NKEY = 11;
`ifdef JTFRAME_KABUKI_CHK_EN
  localparam int WIN = 12;
`else
  localparam int WIN = 11;
`endif
  localparam logic [87:0] KEY_A  = 88'h000102030405060708090A;
  localparam logic [87:0] KEY_B  = 88'hFFFEFDFCFBFAF9F8F7F6F5;
  localparam logic [87:0] KEY_OV = 88'h000122030405060708090A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [25:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  prog_data;
  logic        prog_we, kabuki_en, busy, key_err;

  jtframe_kabuki_keyload #(
    .AW(26), .KEY_ADDR(KADDR), .WE_HOLD(HOLD), .WE_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_data(prog_data), .prog_we(prog_we),
    .kabuki_en(kabuki_en), .busy(busy), .key_err(key_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: key bytes, validity set, and a replay clock k
  typedef enum {M_IDLE, M_CAP, M_REPLAY, M_DONE, M_ERR} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [7:0]  m_buf [12] = '{default: 8'h00};
  logic [11:0] m_mask = '0;
  logic        m_dl = 1'b0;
  int          m_k = 0;
  int          m_i;
  logic [25:0] m_off;
  logic [7:0]  m_x;
  bit          m_ok;
  logic [7:0]  e_data = '0;
  logic        e_we = 1'b0, e_busy = 1'b0, e_en = 1'b0, e_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_mask = '0; m_dl = 1'b0; m_k = 0;
      e_data = '0; e_we = 1'b0; e_busy = 1'b0; e_en = 1'b0; e_err = 1'b0;
    end else begin
      if (downloading && !m_dl) begin
        m_mode = M_CAP;
        m_mask = '0;
      end else begin
        case (m_mode)
          M_CAP: begin
            m_off = ioctl_addr - KADDR;
            if (ioctl_wr && m_off < 26'(WIN)) begin
              m_i = int'(m_off);
              m_buf[m_i]  = ioctl_dout;
              m_mask[m_i] = 1'b1;
            end
            if (!downloading) begin
              m_ok = 1'b1;
              m_x  = '0;
              for (int i = 0; i < NKEY; i++) begin
                if (!m_mask[i]) m_ok = 1'b0;
                m_x ^= m_buf[i];
              end
`ifdef JTFRAME_KABUKI_CHK_EN
              if (!m_mask[11] || m_x != m_buf[11]) m_ok = 1'b0;
`endif
              if (m_ok) begin
                m_mode = M_REPLAY;
                m_k    = 0;
              end else begin
                m_mode = M_ERR;
              end
            end
          end
          M_REPLAY: begin
            m_k++;
            if (m_k == NKEY * SLOT) m_mode = M_DONE;
          end
          default: ;
        endcase
      end
      m_dl = downloading;
      e_we = 1'b0; e_busy = 1'b0; e_en = 1'b0; e_err = 1'b0;
      case (m_mode)
        M_REPLAY: begin
          e_we   = (m_k % SLOT) < HOLD;
          e_busy = 1'b1;
          e_data = m_buf[m_k / SLOT];
        end
        M_DONE: e_en = 1'b1;
        M_ERR:  e_err = 1'b1;
        default: ;
      endcase
    end
  end

  // Decoder emulation and per-cycle compare
  logic [87:0] dec_key = '0;
  int          cyc = 0, pulses = 0, first_cyc = 0, en_cyc = 0;
  logic [7:0]  first_data = '0;
  logic        we_q = 1'b0, en_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prog_we && !we_q) begin
      pulses++;
      if (pulses == 1) begin
        first_cyc  = cyc;
        first_data = prog_data;
      end
    end
    if (!prog_we && we_q) dec_key = {dec_key[79:0], prog_data};
    if (kabuki_en && !en_q) en_cyc = cyc;
    we_q = prog_we;
    en_q = kabuki_en;
    n_total++;
    if ({prog_data, prog_we, busy, kabuki_en, key_err} === {e_data, e_we, e_busy, e_en, e_err})
      n_pass++;
    else
      $display("FAIL cycle %0d outputs: data=%h we=%b busy=%b en=%b err=%b, expected data=%h we=%b busy=%b en=%b err=%b",
               cyc, prog_data, prog_we, busy, kabuki_en, key_err, e_data, e_we, e_busy, e_en, e_err);
  end

  task automatic check(input string name, input logic [87:0] got, input logic [87:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [25:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
    step();
  endtask

  task automatic begin_dl();
    downloading = 1'b1;
    pulses      = 0;
    step();
  endtask

  task automatic end_dl();
    downloading = 1'b0;
    step();
  endtask

  task automatic send_key(input logic [87:0] key, input int omit, input bit flip);
    logic [7:0] b, x;
    x = '0;
    for (int i = 0; i < NKEY; i++) begin
      b = key[87-8*i -: 8];
      x ^= b;
      if (i != omit) wr(KADDR + 26'(i), b);
    end
`ifdef JTFRAME_KABUKI_CHK_EN
    wr(KADDR + 26'd11, x ^ {7'd0, flip});
`else
    if (flip) x = '0;
`endif
  endtask

  task automatic wait_en(input string name);
    int t;
    t = 0;
    while (!kabuki_en && t < 300) begin
      step();
      t++;
    end
    step();
    check(name, 88'(kabuki_en), 88'd1);
  endtask

  task automatic wait_pulse(input string name, input int n);
    int t;
    t = 0;
    while (!(pulses >= n && prog_we) && t < 300) begin
      step();
      t++;
    end
    check(name, 88'(pulses >= n && prog_we), 88'd1);
  endtask

  initial begin
    repeat (3) step();
    check("reset_outputs", 88'({prog_data, prog_we, busy, kabuki_en, key_err}), 88'd0);
    rst = 1'b0;
    step();
    step();

    // Normal load
    begin_dl();
    send_key(KEY_A, -1, 1'b0);
    end_dl();
    wait_en("normal_en");
    check("normal_pulses", 88'(pulses), 88'd11);
    check("normal_key", dec_key, KEY_A);
    check("normal_en_latency", 88'(en_cyc - first_cyc), 88'd44);
    check("normal_first_data", 88'(first_data), 88'h00);
    check("normal_err", 88'(key_err), 88'd0);

    // Window edges and overwrite of index 2
    begin_dl();
    wr(KADDR - 26'd1, 8'h5A);
    wr(KADDR + 26'(WIN), 8'hA5);
    wr(KADDR + 26'd2, 8'h11);
    send_key(KEY_OV, -1, 1'b0);
    end_dl();
    wait_en("ovr_en");
    check("ovr_key", dec_key, KEY_OV);
    check("ovr_pulses", 88'(pulses), 88'd11);

    // Missing byte 7
    begin_dl();
    send_key(KEY_A, 7, 1'b0);
    end_dl();
    repeat (60) step();
    check("miss_err", 88'(key_err), 88'd1);
    check("miss_en", 88'(kabuki_en), 88'd0);
    check("miss_pulses", 88'(pulses), 88'd0);

`ifdef JTFRAME_KABUKI_CHK_EN
    // Checksum with bit 0 flipped
    begin_dl();
    send_key(KEY_A, -1, 1'b1);
    end_dl();
    repeat (60) step();
    check("chk_bad_err", 88'(key_err), 88'd1);
    check("chk_bad_pulses", 88'(pulses), 88'd0);
`endif

    // Abort during byte 5, then re-download
    begin_dl();
    send_key(KEY_A, -1, 1'b0);
    end_dl();
    wait_pulse("abort_reach", 6);
    downloading = 1'b1;
    pulses      = 0;
    step();
    check("abort_we", 88'(prog_we), 88'd0);
    check("abort_busy", 88'(busy), 88'd0);
    step();
    send_key(KEY_B, -1, 1'b0);
    end_dl();
    wait_en("abort_en");
    check("abort_first_data", 88'(first_data), 88'hFF);
    check("abort_key", dec_key, KEY_B);
    check("abort_pulses", 88'(pulses), 88'd11);

    // Reset during byte 3
    begin_dl();
    send_key(KEY_A, -1, 1'b0);
    end_dl();
    wait_pulse("rst_reach", 4);
    rst = 1'b1;
    #1;
    check("rst_async", 88'({prog_data, prog_we, busy, kabuki_en, key_err}), 88'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (60) step();
    check("rst_no_we", 88'(pulses), 88'd4);
    check("rst_en", 88'(kabuki_en), 88'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
